decode_pipe: RTL and testbench
==============================

# decode_pipe

Parametrised decode stage for the 16-bit-instruction processor. It holds the register file, decodes one instruction per cycle into operands, immediate and ALU controls, and registers them into the ID/EX pipeline register. Compared with the earlier single-width decode, it adds a configurable data width and register count, writeback-to-read bypass, stall and flush control, illegal-opcode detection, optional hard-wired R0, and a decoded-instruction counter.

## Interface
- WIDTH, 16, datapath and register width (≥ 8).
- NREG, 16, number of registers (2..16); register index fields are 4 bits.
- ZERO_R0, 0, when 1, R0 reads as 0 and writes to it are dropped.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inst  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [7:0] imm8.
- in_valid  in  1  inst is valid this cycle.
- stall  in  1  hold the ID/EX register.
- flush  in  1  load a bubble into the ID/EX register.
- wer  in  1  writeback enable.
- rdestrr  in  4  writeback register index.
- s2  in  WIDTH  writeback data.
- s0  out  WIDTH  operand A, reg[rd]; 0 for LDI.
- rdo1  out  WIDTH  operand B, reg[rs].
- imme  out  WIDTH  imm8 zero-extended.
- aluc  out  2  00 add, 01 sub, 10 and, 11 or.
- selc_b  out  1  1 = ALU B from imme.
- we  out  1  result is written to rdestr.
- rdestr  out  4  destination index (= rd).
- out_valid  out  1  ID/EX register holds a real instruction.
- illegal  out  1  one-cycle pulse: an illegal instruction was dropped.
- dec_count  out  16  count of instructions loaded into ID/EX.

## Operation
- Opcodes: 0 NOP (valid, we=0); 1 ADD; 2 SUB; 3 AND; 4 OR (selc_b=0, we=1); 9 ADDI; A SUBI (selc_b=1, we=1); C LDI (aluc=00, selc_b=1, s0=0, we=1). All other opcodes are illegal. Any rd or rs ≥ NREG is also illegal.
- Register file: NREG×WIDTH. Written on a clk edge when wer=1 and rdestrr<NREG, except when ZERO_R0=1 and rdestrr=0. Writes with rdestrr≥NREG are ignored.
- Read bypass: if wer=1 and rdestrr equals a source index in the same cycle, that operand takes s2 instead of the array value. The bypass respects ZERO_R0 and the ≥NREG rule.
- Priority at the clk edge: rst > flush > stall > load.
- Load, when in_valid=1 and the instruction is legal: every output field takes the decoded value, out_valid=1, and dec_count increments (modulo 2^16).
- Illegal instruction with in_valid=1: a bubble is loaded and illegal=1 for one cycle. dec_count does not change.
- in_valid=0: a bubble is loaded.
- Bubble: all output fields are 0 and out_valid=0.
- Stall: all fields hold and no new instruction is loaded. However, if wer=1 and rdestrr matches the held rd or rs, the held s0 or rdo1 is updated to s2. Held s0 for LDI stays 0. Register-file writes still occur.
- Flush, including flush together with stall: a bubble is loaded, illegal=0, and dec_count holds.

## Timing
- Decode latency is 1 cycle: inst sampled at edge N appears on the outputs after edge N.
- A write at edge N is visible in the array from cycle N+1. An instruction decoded in cycle N sees it through the bypass.
- Reset (synchronous): register file cleared to 0; all outputs 0, including out_valid, illegal and dec_count. Reset asserted mid-stall clears the held instruction.
- illegal is a registered pulse that is never held during a stall; it is 0 in any stall cycle.
- WIDTH affects only data paths. imme is imm8 zero-extended to WIDTH.

## Test plan
- Writeback then ADD: write AAAA to R0 and BBBB to R1, then inst=1010 → s0=AAAA, rdo1=BBBB, aluc=00, selc_b=0, we=1, rdestr=0, dec_count=1.
- Immediates: inst=C188 → s0=0, imme=0088, selc_b=1, we=1, rdestr=1. Then inst=A148 → aluc=01, imme=0048, s0=reg[1].
- Bypass: wer=1, rdestrr=1, s2=1234 in the same cycle as inst=1010 → rdo1=1234. With stall=1 and an R1 write of 5678 → held rdo1=5678 and all other fields unchanged.
- Flush vs stall: stall=1 and flush=1 together → out_valid=0, all fields 0, dec_count unchanged.
- Illegal: inst=F000 → bubble, illegal=1 for exactly one cycle. With NREG=8, inst=1090 (rs=9) → illegal. ZERO_R0=1, write FFFF to R0, then inst=1000 → s0=0.
- Reset and wrap: drive 65536 legal instructions → dec_count wraps to 0. Assert rst mid-stream → all outputs 0 and the register file reads 0 on the next decode.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode stage: register file, instruction decode, and the ID/EX pipeline register.
// Reads bypass the same-cycle writeback; a stalled ID/EX entry also picks up
// writebacks aimed at its source registers so it never goes stale while held.
module decode_pipe #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      inst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             wer,
  input  logic [3:0]       rdestrr,
  input  logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] rdo1,
  output logic [WIDTH-1:0] imme,
  output logic [1:0]       aluc,
  output logic             selc_b,
  output logic             we,
  output logic [3:0]       rdestr,
  output logic             out_valid,
  output logic             illegal,
  output logic [15:0]      dec_count
);

  logic [WIDTH-1:0] rf [NREG];

  logic [3:0] f_op, f_rd, f_rs;
  logic [7:0] f_imm;

  assign f_op  = inst[15:12];
  assign f_rd  = inst[11:8];
  assign f_rs  = inst[7:4];
  assign f_imm = inst[7:0];

  // A register index that exists and may actually be written (R0 excluded when hard-wired).
  function automatic logic writable(input logic [3:0] idx);
    return (int'(idx) < NREG) && !((ZERO_R0 != 0) && (idx == 4'd0));
  endfunction

  logic             wb_ok;
  logic [WIDTH-1:0] rf_a, rf_b, opnd_a, opnd_b;

  assign wb_ok = wer && writable(rdestrr);

  // Array read for both source fields, then same-cycle writeback bypass.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (f_rd == i[3:0]) rf_a = rf[i];
      if (f_rs == i[3:0]) rf_b = rf[i];
    end
    opnd_a = (wb_ok && (rdestrr == f_rd)) ? s2 : rf_a;
    opnd_b = (wb_ok && (rdestrr == f_rs)) ? s2 : rf_b;
  end

  logic       d_opok, d_selb, d_we, d_ldi, d_legal;
  logic [1:0] d_aluc;

  // Opcode table; anything not listed is illegal.
  always_comb begin
    d_opok = 1'b1;
    d_aluc = 2'b00;
    d_selb = 1'b0;
    d_we   = 1'b0;
    d_ldi  = 1'b0;
    case (f_op)
      4'h0: ;
      4'h1: d_we = 1'b1;
      4'h2: begin d_aluc = 2'b01; d_we = 1'b1; end
      4'h3: begin d_aluc = 2'b10; d_we = 1'b1; end
      4'h4: begin d_aluc = 2'b11; d_we = 1'b1; end
      4'h9: begin d_selb = 1'b1; d_we = 1'b1; end
      4'hA: begin d_aluc = 2'b01; d_selb = 1'b1; d_we = 1'b1; end
      4'hC: begin d_selb = 1'b1; d_we = 1'b1; d_ldi = 1'b1; end
      default: d_opok = 1'b0;
    endcase
    d_legal = d_opok && (int'(f_rd) < NREG) && (int'(f_rs) < NREG);
  end

  // Register file: cleared by reset, written from the writeback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_ok) begin
      for (int i = 0; i < NREG; i++)
        if (rdestrr == i[3:0]) rf[i] <= s2;
    end
  end

  logic [3:0] held_rs;
  logic       held_ldi;
  logic       take, hold, upd_a, upd_b;

  // A flush wins over a stall; take is a real load into ID/EX.
  assign hold  = stall && !flush;
  assign take  = in_valid && d_legal && !flush;
  assign upd_a = out_valid && !held_ldi && wb_ok && (rdestrr == rdestr);
  assign upd_b = out_valid && wb_ok && (rdestrr == held_rs);

  // ID/EX register: reset, hold-with-refresh on stall, otherwise load or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0        <= '0;
      rdo1      <= '0;
      imme      <= '0;
      aluc      <= '0;
      selc_b    <= 1'b0;
      we        <= 1'b0;
      rdestr    <= '0;
      held_rs   <= '0;
      held_ldi  <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      dec_count <= '0;
    end else if (hold) begin
      illegal <= 1'b0;
      if (upd_a) s0   <= s2;
      if (upd_b) rdo1 <= s2;
    end else begin
      s0        <= (take && !d_ldi) ? opnd_a : '0;
      rdo1      <= take ? opnd_b : '0;
      imme      <= take ? WIDTH'(f_imm) : '0;
      aluc      <= take ? d_aluc : 2'b00;
      selc_b    <= take && d_selb;
      we        <= take && d_we;
      rdestr    <= take ? f_rd : 4'd0;
      held_rs   <= take ? f_rs : 4'd0;
      held_ldi  <= take && d_ldi;
      out_valid <= take;
      illegal   <= in_valid && !d_legal && !flush;
      if (take) dec_count <= dec_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: three instances (default, NREG=8, ZERO_R0=1) share one
// stimulus stream; a behavioural model checks every output every cycle, and
// directed checks pin hand-computed values.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, wer;
  logic [15:0] inst, s2;
  logic [3:0]  rdestrr;

  logic [15:0] o_s0 [3], o_rdo1 [3], o_imme [3], o_dc [3];
  logic [1:0]  o_aluc [3];
  logic [3:0]  o_rdestr [3];
  logic        o_selb [3], o_we [3], o_ov [3], o_ill [3];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    decode_pipe #(.WIDTH(16), .NREG(g == 1 ? 8 : 16), .ZERO_R0(g == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .stall(stall),
      .flush(flush), .wer(wer), .rdestrr(rdestrr), .s2(s2),
      .s0(o_s0[g]), .rdo1(o_rdo1[g]), .imme(o_imme[g]), .aluc(o_aluc[g]),
      .selc_b(o_selb[g]), .we(o_we[g]), .rdestr(o_rdestr[g]), .out_valid(o_ov[g]),
      .illegal(o_ill[g]), .dec_count(o_dc[g])
    );
  end

  // ---------------- behavioural model ----------------
  logic [15:0] mrf [3][16];
  logic [15:0] e_s0 [3], e_rdo1 [3], e_imme [3], e_dc [3];
  logic [1:0]  e_aluc [3];
  logic [3:0]  e_rdestr [3];
  logic        e_selb [3], e_we [3], e_ov [3], e_ill [3];
  int          e_rs [3];
  bit          e_ldi [3];

  function automatic int nreg_of(int k);
    return (k == 1) ? 8 : 16;
  endfunction

  function automatic bit can_write(int k, int idx);
    return (idx < nreg_of(k)) && !(k == 2 && idx == 0);
  endfunction

  function automatic logic [15:0] read_reg(int k, int idx);
    if (!can_write(k, idx)) return 16'h0;
    if (wer && int'(rdestrr) == idx) return s2;
    return mrf[k][idx];
  endfunction

  task automatic bubble(int k);
    e_s0[k] = 0; e_rdo1[k] = 0; e_imme[k] = 0; e_aluc[k] = 0; e_selb[k] = 0;
    e_we[k] = 0; e_rdestr[k] = 0; e_ov[k] = 0; e_rs[k] = 0; e_ldi[k] = 0;
  endtask

  task automatic model_step(int k);
    int op, rd, rs;
    bit ok, sb, w, ldi, legal;
    logic [1:0] al;
    op = int'(inst[15:12]); rd = int'(inst[11:8]); rs = int'(inst[7:4]);
    ok = 1; al = 0; sb = 0; w = 1; ldi = 0;
    case (op)
      0:       w = 0;
      1, 2, 3, 4: al = 2'(op - 1);
      9:       sb = 1;
      10:      begin al = 1; sb = 1; end
      12:      begin sb = 1; ldi = 1; end
      default: ok = 0;
    endcase
    legal = ok && rd < nreg_of(k) && rs < nreg_of(k);
    if (rst) begin
      bubble(k); e_ill[k] = 0; e_dc[k] = 0;
    end else if (flush) begin
      bubble(k); e_ill[k] = 0;
    end else if (stall) begin
      e_ill[k] = 0;
      if (e_ov[k] && wer && can_write(k, int'(rdestrr))) begin
        if (int'(rdestrr) == int'(e_rdestr[k]) && !e_ldi[k]) e_s0[k] = s2;
        if (int'(rdestrr) == e_rs[k]) e_rdo1[k] = s2;
      end
    end else if (in_valid && legal) begin
      e_s0[k] = ldi ? 16'h0 : read_reg(k, rd);
      e_rdo1[k] = read_reg(k, rs);
      e_imme[k] = {8'h00, inst[7:0]};
      e_aluc[k] = al; e_selb[k] = sb; e_we[k] = w;
      e_rdestr[k] = 4'(rd); e_rs[k] = rs; e_ldi[k] = ldi;
      e_ov[k] = 1; e_ill[k] = 0; e_dc[k] = e_dc[k] + 16'd1;
    end else begin
      bubble(k); e_ill[k] = in_valid;
    end
    if (rst) for (int i = 0; i < 16; i++) mrf[k][i] = 0;
    else if (wer && can_write(k, int'(rdestrr))) mrf[k][int'(rdestrr)] = s2;
  endtask

  // Advance the model on every rising edge, from the inputs the DUT also samples.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    if (rst) armed = 1'b1;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk("m_s0", k, 32'(o_s0[k]), 32'(e_s0[k]));
        chk("m_rdo1", k, 32'(o_rdo1[k]), 32'(e_rdo1[k]));
        chk("m_imme", k, 32'(o_imme[k]), 32'(e_imme[k]));
        chk("m_aluc", k, 32'(o_aluc[k]), 32'(e_aluc[k]));
        chk("m_selc_b", k, 32'(o_selb[k]), 32'(e_selb[k]));
        chk("m_we", k, 32'(o_we[k]), 32'(e_we[k]));
        chk("m_rdestr", k, 32'(o_rdestr[k]), 32'(e_rdestr[k]));
        chk("m_out_valid", k, 32'(o_ov[k]), 32'(e_ov[k]));
        chk("m_illegal", k, 32'(o_ill[k]), 32'(e_ill[k]));
        chk("m_dec_count", k, 32'(o_dc[k]), 32'(e_dc[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit r, input logic [15:0] i, input bit v, input bit st,
                     input bit fl, input bit w, input logic [3:0] wr, input logic [15:0] d);
    @(negedge clk);
    rst = r; inst = i; in_valid = v; stall = st; flush = fl; wer = w; rdestrr = wr; s2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; inst = 0; in_valid = 0; stall = 0; flush = 0; wer = 0; rdestrr = 0; s2 = 0;
    cyc(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_ov", 0, 32'(o_ov[0]), 0);
    chk("rst_dc", 0, 32'(o_dc[0]), 0);
    chk("rst_s0", 0, 32'(o_s0[0]), 0);

    // writeback then ADD
    cyc(0, 16'h0000, 0, 0, 0, 1, 4'd0, 16'hAAAA);
    cyc(0, 16'h0000, 0, 0, 0, 1, 4'd1, 16'hBBBB);
    cyc(0, 16'h1010, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("add_s0", 0, 32'(o_s0[0]), 32'hAAAA);
    chk("add_rdo1", 0, 32'(o_rdo1[0]), 32'hBBBB);
    chk("add_aluc", 0, 32'(o_aluc[0]), 0);
    chk("add_selb", 0, 32'(o_selb[0]), 0);
    chk("add_we", 0, 32'(o_we[0]), 1);
    chk("add_rdestr", 0, 32'(o_rdestr[0]), 0);
    chk("add_dc", 0, 32'(o_dc[0]), 1);
    chk("add_zr0_s0", 2, 32'(o_s0[2]), 0);

    // immediates
    cyc(0, 16'hC188, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("ldi_s0", 0, 32'(o_s0[0]), 0);
    chk("ldi_imme", 0, 32'(o_imme[0]), 32'h0088);
    chk("ldi_selb", 0, 32'(o_selb[0]), 1);
    chk("ldi_rdestr", 0, 32'(o_rdestr[0]), 1);
    chk("ldi_n8_illegal", 1, 32'(o_ill[1]), 1);
    cyc(0, 16'h0000, 0, 1, 0, 1, 4'd1, 16'h7777);
    chk("ldi_stall_s0", 0, 32'(o_s0[0]), 0);
    cyc(0, 16'hA148, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("subi_aluc", 0, 32'(o_aluc[0]), 1);
    chk("subi_imme", 0, 32'(o_imme[0]), 32'h0048);
    chk("subi_s0", 0, 32'(o_s0[0]), 32'h7777);
    chk("subi_dc", 0, 32'(o_dc[0]), 3);

    // bypass, then refresh while stalled
    cyc(0, 16'h1010, 1, 0, 0, 1, 4'd1, 16'h1234);
    chk("byp_rdo1", 0, 32'(o_rdo1[0]), 32'h1234);
    chk("byp_s0", 0, 32'(o_s0[0]), 32'hAAAA);
    cyc(0, 16'hF000, 1, 1, 0, 1, 4'd1, 16'h5678);
    chk("stall_rdo1", 0, 32'(o_rdo1[0]), 32'h5678);
    chk("stall_s0", 0, 32'(o_s0[0]), 32'hAAAA);
    chk("stall_ov", 0, 32'(o_ov[0]), 1);
    chk("stall_ill", 0, 32'(o_ill[0]), 0);
    chk("stall_dc", 0, 32'(o_dc[0]), 4);

    // flush together with stall
    cyc(0, 16'h1010, 1, 1, 1, 0, 4'd0, 16'h0);
    chk("flush_ov", 0, 32'(o_ov[0]), 0);
    chk("flush_s0", 0, 32'(o_s0[0]), 0);
    chk("flush_rdo1", 0, 32'(o_rdo1[0]), 0);
    chk("flush_dc", 0, 32'(o_dc[0]), 4);

    // illegal opcode and out-of-range index
    cyc(0, 16'hF000, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("ill_pulse", 0, 32'(o_ill[0]), 1);
    chk("ill_ov", 0, 32'(o_ov[0]), 0);
    cyc(0, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0);
    chk("ill_clear", 0, 32'(o_ill[0]), 0);
    cyc(0, 16'h1090, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("rs9_n8_ill", 1, 32'(o_ill[1]), 1);
    chk("rs9_n16_ov", 0, 32'(o_ov[0]), 1);

    // hard-wired R0
    cyc(0, 16'h0000, 0, 0, 0, 1, 4'd0, 16'hFFFF);
    cyc(0, 16'h1000, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("zr0_s0", 2, 32'(o_s0[2]), 0);
    chk("r0_s0", 0, 32'(o_s0[0]), 32'hFFFF);

    // reset mid-stall
    cyc(0, 16'h1010, 1, 0, 0, 0, 4'd0, 16'h0);
    cyc(1, 16'h1010, 1, 1, 0, 0, 4'd0, 16'h0);
    chk("rstmid_ov", 0, 32'(o_ov[0]), 0);
    chk("rstmid_s0", 0, 32'(o_s0[0]), 0);
    chk("rstmid_dc", 0, 32'(o_dc[0]), 0);
    cyc(0, 16'h1010, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("rstmid_rf_s0", 0, 32'(o_s0[0]), 0);
    chk("rstmid_rf_rdo1", 0, 32'(o_rdo1[0]), 0);
    chk("rstmid_dc1", 0, 32'(o_dc[0]), 1);

    // counter wrap
    cyc(1, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0);
    for (int n = 0; n < 65535; n++) cyc(0, 16'h0000, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("wrap_ffff", 0, 32'(o_dc[0]), 32'hFFFF);
    cyc(0, 16'h0000, 1, 0, 0, 0, 4'd0, 16'h0);
    chk("wrap_zero", 0, 32'(o_dc[0]), 0);
    chk("wrap_ov", 0, 32'(o_ov[0]), 1);

    cyc(0, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
